// File: rtl/tnet_cmd_ctrl.sv
// tnet_cmd_ctrl
//
// Command sequencer between the TNET AXI register block and the TNET link core.
// Software sets exec/clear bits in TNET_CTRL. The 0->1 edges of those bits
// start a command or clear the error code. A started command takes a snapshot
// of its arguments and is offered to the core over valid/ready. Completion is
// then awaited, bounded by a timeout. Status, error and statistics are
// reported through TNET_STATUS and TNET_DEBUG.
//
// Ports
//   ps_aclk, ps_aresetn          clock, async active-low reset
//   TNET_CTRL[31:0]              [0] exec strobe, [5:1] opcode, [7] clear-error strobe
//   TNET_ADDR, TNET_LEN [15:0]   command arguments
//   REG_AXI_DT1..DT3 [31:0]      data arguments
//   cmd_valid_o / cmd_ready_i    command handshake with the core
//   cmd_op_o, cmd_addr_o,
//   cmd_len_o, cmd_dt_o          latched command fields (dt = {DT3, DT2, DT1})
//   cmd_done_i, cmd_err_i        completion pulse, error qualifier sampled with done
//   TNET_STATUS, TNET_DEBUG      status and debug words
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no command in flight; a legal exec edge starts one
// ISSUE  | command offered to the core (cmd_valid_o = 1)
// WAIT   | command accepted; waiting for cmd_done_i or the timeout

module tnet_cmd_ctrl #(
    parameter int NUM_OP  = 12,
    parameter int TIMEOUT = 50000
) (
    input  logic        ps_aclk,
    input  logic        ps_aresetn,
    input  logic [31:0] TNET_CTRL,
    input  logic [15:0] TNET_ADDR,
    input  logic [15:0] TNET_LEN,
    input  logic [31:0] REG_AXI_DT1,
    input  logic [31:0] REG_AXI_DT2,
    input  logic [31:0] REG_AXI_DT3,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [4:0]  cmd_op_o,
    output logic [15:0] cmd_addr_o,
    output logic [15:0] cmd_len_o,
    output logic [95:0] cmd_dt_o,
    input  logic        cmd_done_i,
    input  logic        cmd_err_i,
    output logic [31:0] TNET_STATUS,
    output logic [31:0] TNET_DEBUG
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [4:0]    MAX_OP   = 5'(NUM_OP);

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BAD_OP  = 3'd1;
    localparam logic [2:0] ERR_CORE    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_BUSY    = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_armed;
    logic          r_exec_q;
    logic          r_clr_q;
    logic          r_valid;
    logic [4:0]    r_op;
    logic [15:0]   r_addr;
    logic [15:0]   r_len;
    logic [95:0]   r_dt;
    logic [TW-1:0] r_tmo;
    logic [15:0]   r_lat;
    logic [15:0]   r_last_lat;
    logic [15:0]   r_done_cnt;
    logic [15:0]   r_rej_cnt;
    logic [2:0]    r_err;

    logic          w_exec_edge;
    logic          w_clr_edge;
    logic [4:0]    w_op;
    logic          w_op_legal;
    logic          w_busy;
    logic          w_tmo_hit;
    logic          w_complete;
    logic          w_timeout;
    logic          w_reject;
    logic          w_err_set;
    logic [2:0]    w_err_code;
    logic [15:0]   w_lat_next;
    logic          w_unused_ctrl;

    // r_armed keeps the first cycle after reset release from firing, so a
    // bit that is already high at release is not seen as an edge.
    assign w_exec_edge = r_armed & TNET_CTRL[0] & ~r_exec_q;
    assign w_clr_edge  = r_armed & TNET_CTRL[7] & ~r_clr_q;
    assign w_op        = TNET_CTRL[5:1];
    assign w_op_legal  = (w_op != 5'd0) && (w_op <= MAX_OP);

    assign w_busy      = (r_state != S_IDLE);
    assign w_tmo_hit   = w_busy && (r_tmo == TMO_LAST);

    // Completion wins over a timeout landing in the same cycle.
    assign w_complete  = ((r_state == S_ISSUE) && cmd_ready_i && cmd_done_i) ||
                         ((r_state == S_WAIT) && cmd_done_i);
    assign w_timeout   = w_tmo_hit && !w_complete;

    assign w_lat_next  = (r_lat == 16'hFFFF) ? r_lat : r_lat + 16'd1;

    assign w_unused_ctrl = ^{TNET_CTRL[31:8], TNET_CTRL[6]};

    always_comb begin
        w_reject   = 1'b0;
        w_err_set  = 1'b0;
        w_err_code = ERR_NONE;
        if (w_complete && cmd_err_i) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_CORE;
        end
        if (w_timeout) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_TIMEOUT;
        end
        if (w_exec_edge) begin
            if (w_busy) begin
                w_reject   = 1'b1;
                w_err_set  = 1'b1;
                w_err_code = ERR_BUSY;
            end else if (!w_op_legal) begin
                w_reject   = 1'b1;
                w_err_set  = 1'b1;
                w_err_code = ERR_BAD_OP;
            end
        end
    end

    always_ff @(posedge ps_aclk or negedge ps_aresetn) begin
        if (!ps_aresetn) begin
            r_state    <= S_IDLE;
            r_armed    <= 1'b0;
            r_exec_q   <= 1'b0;
            r_clr_q    <= 1'b0;
            r_valid    <= 1'b0;
            r_op       <= 5'd0;
            r_addr     <= 16'd0;
            r_len      <= 16'd0;
            r_dt       <= 96'd0;
            r_tmo      <= '0;
            r_lat      <= 16'd0;
            r_last_lat <= 16'd0;
            r_done_cnt <= 16'd0;
            r_rej_cnt  <= 16'd0;
            r_err      <= ERR_NONE;
        end else begin
            r_armed  <= 1'b1;
            r_exec_q <= TNET_CTRL[0];
            r_clr_q  <= TNET_CTRL[7];

            // A new error in the same cycle as a clear edge is kept.
            if (w_err_set) begin
                r_err <= w_err_code;
            end else if (w_clr_edge) begin
                r_err <= ERR_NONE;
            end

            if (w_reject && (r_rej_cnt != 16'hFFFF)) begin
                r_rej_cnt <= r_rej_cnt + 16'd1;
            end

            if (w_complete) begin
                r_done_cnt <= r_done_cnt + 16'd1;
                r_last_lat <= r_lat;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_exec_edge && w_op_legal) begin
                        r_op    <= w_op;
                        r_addr  <= TNET_ADDR;
                        r_len   <= TNET_LEN;
                        r_dt    <= {REG_AXI_DT3, REG_AXI_DT2, REG_AXI_DT1};
                        r_tmo   <= '0;
                        r_lat   <= 16'd0;
                        r_valid <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tmo <= r_tmo + TW'(1);
                    r_lat <= w_lat_next;
                    if (w_complete || w_timeout) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (cmd_ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_tmo <= r_tmo + TW'(1);
                    r_lat <= w_lat_next;
                    if (w_complete || w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid_o = r_valid;
    assign cmd_op_o    = r_op;
    assign cmd_addr_o  = r_addr;
    assign cmd_len_o   = r_len;
    assign cmd_dt_o    = r_dt;

    assign TNET_STATUS = {r_done_cnt, 3'b000, r_op, r_err, (r_err != ERR_NONE),
                          1'b0, (r_state == S_WAIT), r_valid, w_busy};
    assign TNET_DEBUG  = {r_last_lat, r_rej_cnt};

endmodule

// File: tb/tb_tnet_cmd_ctrl.sv
module tb_tnet_cmd_ctrl;

    localparam int NUM_OP = 12;
    localparam int TMO    = 20;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ctrl;
    logic [15:0] addr;
    logic [15:0] len;
    logic [31:0] dt1, dt2, dt3;
    logic        ready, done, err_i;
    logic        valid;
    logic [4:0]  op_o;
    logic [15:0] addr_o, len_o;
    logic [95:0] dt_o;
    logic [31:0] status, debug;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: architectural registers only, updated per the
    // command-level rules of the sequencer.
    logic [15:0] m_done, m_rej, m_lat;
    logic [2:0]  m_err;
    logic [4:0]  m_op;
    logic [15:0] e_addr, e_len;
    logic [95:0] e_dt;

    always #5 clk = ~clk;

    tnet_cmd_ctrl #(.NUM_OP(NUM_OP), .TIMEOUT(TMO)) dut (
        .ps_aclk     (clk),
        .ps_aresetn  (rst_n),
        .TNET_CTRL   (ctrl),
        .TNET_ADDR   (addr),
        .TNET_LEN    (len),
        .REG_AXI_DT1 (dt1),
        .REG_AXI_DT2 (dt2),
        .REG_AXI_DT3 (dt3),
        .cmd_valid_o (valid),
        .cmd_ready_i (ready),
        .cmd_op_o    (op_o),
        .cmd_addr_o  (addr_o),
        .cmd_len_o   (len_o),
        .cmd_dt_o    (dt_o),
        .cmd_done_i  (done),
        .cmd_err_i   (err_i),
        .TNET_STATUS (status),
        .TNET_DEBUG  (debug)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input logic busy, input logic v, input logic w);
        return {m_done, 3'b000, m_op, m_err, (m_err != 3'd0), 1'b0, w, v, busy};
    endfunction

    function automatic logic [31:0] exp_debug();
        return {m_lat, m_rej};
    endfunction

    task automatic model_reset();
        m_done = '0; m_rej = '0; m_lat = '0; m_err = '0; m_op = '0;
        e_addr = '0; e_len = '0; e_dt = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_op"}, op_o, 5'd0);
        check({tag, "_addr"}, addr_o, 16'd0);
        check({tag, "_len"}, len_o, 16'd0);
        check({tag, "_dt"}, dt_o, 96'd0);
        check({tag, "_status"}, status, 32'd0);
        check({tag, "_debug"}, debug, 32'd0);
    endtask

    task automatic check_fields();
        check("fld_op", op_o, m_op);
        check("fld_addr", addr_o, e_addr);
        check("fld_len", len_o, e_len);
        check("fld_dt", dt_o, e_dt);
    endtask

    task automatic start_exec(input logic [4:0] op, input logic [15:0] a, input logic [15:0] l);
        addr = a; len = l;
        dt1 = $urandom; dt2 = $urandom; dt3 = $urandom;
        ready = 1'b0; done = 1'b0; err_i = 1'b0;
        ctrl = ($urandom & 32'hFFFF_FF40) | {26'd0, op, 1'b1};
        tick();
        m_op = op; e_addr = a; e_len = l; e_dt = {dt3, dt2, dt1};
        ctrl[0] = 1'b0;
        // Disturb the argument inputs to show the fields are latched.
        addr = ~a; len = ~l; dt1 = ~dt1; dt2 = ~dt2; dt3 = ~dt3;
        check("issue_status", status, exp_status(1'b1, 1'b1, 1'b0));
        check_fields();
    endtask

    // Ready is held from ISSUE cycle r, done pulses on ISSUE/WAIT cycle d
    // (cycle 0 = first ISSUE cycle), optional extra exec edge on cycle rej_at.
    task automatic run_cmd(input logic [4:0] op, input logic [15:0] a, input logic [15:0] l,
                           input int r, input int d, input logic e, input int rej_at);
        start_exec(op, a, l);
        for (int i = 0; i <= d; i++) begin
            ready   = (i >= r);
            done    = (i == d);
            err_i   = e & (i == d);
            ctrl[0] = (i == rej_at);
            if (i == rej_at) ctrl[5:1] = 5'($urandom);
            tick();
            if (i == rej_at) begin
                m_err = 3'd4;
                if (m_rej != 16'hFFFF) m_rej++;
            end
            if (i == d) begin
                m_done++;
                m_lat = 16'(d);
                if (e) m_err = 3'd2;
            end
            check("cyc_status", status, exp_status(i < d, i < r, (i >= r) && (i < d)));
            check("cyc_debug", debug, exp_debug());
            if (i < r) check_fields();
        end
        ready = 1'b0; done = 1'b0; err_i = 1'b0; ctrl[0] = 1'b0;
        check("op_held", op_o, m_op);
        tick();
        check("post_status", status, exp_status(1'b0, 1'b0, 1'b0));
    endtask

    // r < 0: ready never asserted; otherwise ready held from ISSUE cycle r.
    task automatic run_timeout(input int r);
        int vcount;
        start_exec(5'($urandom_range(1, NUM_OP)), 16'($urandom), 16'($urandom));
        vcount = 1;
        for (int i = 0; i < TMO; i++) begin
            ready = (r >= 0) && (i >= r);
            tick();
            if (i == TMO - 1) m_err = 3'd3;
            if (valid === 1'b1) vcount++;
            check("tmo_status", status,
                  exp_status(i < TMO - 1, (r < 0) ? (i < TMO - 1) : (i < r),
                             (r >= 0) && (i >= r) && (i < TMO - 1)));
            check("tmo_debug", debug, exp_debug());
        end
        ready = 1'b0;
        if (r < 0) check("tmo_valid_cycles", 32'(vcount), 32'(TMO));
        done = 1'b1;
        tick();
        done = 1'b0;
        check("late_done_status", status, exp_status(1'b0, 1'b0, 1'b0));
        check("late_done_debug", debug, exp_debug());
        tick();
        check("late_done_status2", status, exp_status(1'b0, 1'b0, 1'b0));
    endtask

    task automatic illegal(input logic [4:0] op, input logic clr);
        ctrl = ($urandom & 32'hFFFF_FF40) | {26'd0, op, 1'b1} | (clr ? 32'h80 : 32'h0);
        tick();
        m_err = 3'd1;
        if (m_rej != 16'hFFFF) m_rej++;
        ctrl[0] = 1'b0; ctrl[7] = 1'b0;
        check("ill_valid", valid, 1'b0);
        check("ill_status", status, exp_status(1'b0, 1'b0, 1'b0));
        check("ill_debug", debug, exp_debug());
        tick();
        check("ill_valid2", valid, 1'b0);
    endtask

    task automatic do_clear();
        ctrl[7] = 1'b1;
        tick();
        m_err = 3'd0;
        ctrl[7] = 1'b0;
        check("clr_status", status, exp_status(1'b0, 1'b0, 1'b0));
        tick();
    endtask

    initial begin
        int r, d, rej;
        ctrl = '0; addr = '0; len = '0; dt1 = '0; dt2 = '0; dt3 = '0;
        ready = 1'b0; done = 1'b0; err_i = 1'b0;
        model_reset();
        tick(); tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick(); tick();

        // Opcode 3, ready held high, done on cycle 6 after ISSUE entry.
        run_cmd(5'd3, 16'h1234, 16'h0010, 0, 6, 1'b0, -1);
        check("tp1_status", status, 32'h0001_0300);
        check("tp1_lat", debug[31:16], 16'd6);

        // Illegal opcodes.
        illegal(5'd0, 1'b0);
        illegal(5'd13, 1'b0);
        check("tp2_err", status[7:5], 3'd1);
        check("tp2_rej", debug[15:0], 16'd2);
        illegal(5'($urandom_range(13, 31)), 1'b0);

        // Exec edge while busy.
        run_cmd(5'($urandom_range(1, NUM_OP)), 16'($urandom), 16'($urandom), 1, 6, 1'b0, 3);
        check("tp3_err", status[7:5], 3'd4);
        check("tp3_done", status[31:16], 16'd2);

        // Timeouts from ISSUE and from WAIT.
        run_timeout(-1);
        check("tp4_err", status[7:5], 3'd3);
        run_timeout(2);

        // Core error, clear, clear + illegal exec together.
        run_cmd(5'($urandom_range(1, NUM_OP)), 16'($urandom), 16'($urandom), 0, 3, 1'b1, -1);
        check("tp5_err", status[7:5], 3'd2);
        do_clear();
        check("tp5_clr", status[4], 1'b0);
        illegal(5'd0, 1'b1);
        check("tp5_clr_ill", status[7:5], 3'd1);

        // Randomized commands.
        for (int k = 0; k < 10; k++) begin
            r   = $urandom_range(0, 4);
            d   = r + $urandom_range(0, 10);
            rej = ((k % 2 == 1) && (d >= 2)) ? $urandom_range(1, d - 1) : -1;
            run_cmd(5'($urandom_range(1, NUM_OP)), 16'($urandom), 16'($urandom),
                    r, d, 1'($urandom), rej);
            if ($urandom_range(0, 2) == 0) do_clear();
            if ($urandom_range(0, 2) == 0) illegal(5'($urandom_range(13, 31)), 1'($urandom));
        end

        // Exec bit high through reset release.
        ready = 1'b0; done = 1'b0;
        ctrl = {26'd0, 5'd3, 1'b1};
        rst_n = 1'b0;
        tick(); tick();
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rel_status", status, 32'd0);
            check("rel_valid", valid, 1'b0);
        end
        ctrl[0] = 1'b0;
        tick();

        // Reset pulse during ISSUE.
        start_exec(5'($urandom_range(1, NUM_OP)), 16'($urandom), 16'($urandom));
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("rst_issue");
        tick();
        check_zero_outputs("rst_issue_edge");
        model_reset();
        rst_n = 1'b1;
        tick(); tick();
        run_cmd(5'($urandom_range(1, NUM_OP)), 16'($urandom), 16'($urandom), 2, 5, 1'b0, -1);
        check("after_rst_done", status[31:16], 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
